// File: rtl/count_change_logger.sv
// count_change_logger
// Watches two event-counter outputs and logs one record into a small
// first-word-fall-through FIFO on every cycle in which either count changes.
// A record is {chg[1:0], wrap[1:0], val0, val1}. Records are drained with a
// valid/ready handshake. Records that arrive while the FIFO is full (and not
// being popped on the same edge) are dropped: Overflow sticks high and
// DropCnt counts them, saturating at all-ones.
//
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   Count0, Count1    monitored count values (CNT_W bits each)
//   ClrOvf            clears Overflow/DropCnt (a same-edge drop wins)
//   OutReady          consumer takes the head record this cycle
//   OutValid          head record is valid (FIFO non-empty)
//   OutChg, OutWrap   head record change / wrap flags, bit i = channel i
//   OutVal0, OutVal1  head record count values
//   Level             number of stored records, 0..DEPTH
//   Overflow          sticky drop flag
//   DropCnt           saturating drop counter
module count_change_logger #(
   parameter int CNT_W  = 4,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [CNT_W-1:0]           Count0,
   input  logic [CNT_W-1:0]           Count1,
   input  logic                       ClrOvf,
   input  logic                       OutReady,
   output logic                       OutValid,
   output logic [1:0]                 OutChg,
   output logic [1:0]                 OutWrap,
   output logic [CNT_W-1:0]           OutVal0,
   output logic [CNT_W-1:0]           OutVal1,
   output logic [$clog2(DEPTH):0]     Level,
   output logic                       Overflow,
   output logic [DROP_W-1:0]          DropCnt
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LW    = AW + 1;
   localparam int REC_W = 4 + 2 * CNT_W;

   logic [REC_W-1:0]  mem_q [DEPTH];
   logic [REC_W-1:0]  mem_d [DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              armed_q, armed_d;
   logic [CNT_W-1:0]  prev0_q, prev0_d;
   logic [CNT_W-1:0]  prev1_q, prev1_d;
   logic              ovf_q, ovf_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic              chg0, chg1, wrap0, wrap1;
   logic              push, pop, full, do_write, do_drop;
   logic [REC_W-1:0]  rec;

   always_comb begin
      // Nothing is compared until the arming edge has captured a baseline.
      chg0  = armed_q && (Count0 != prev0_q);
      chg1  = armed_q && (Count1 != prev1_q);
      wrap0 = chg0 && (Count0 < prev0_q);
      wrap1 = chg1 && (Count1 < prev1_q);
      rec   = {chg1, chg0, wrap1, wrap0, Count0, Count1};

      push     = chg0 | chg1;
      pop      = (level_q != '0) && OutReady;
      full     = (level_q == LW'(DEPTH));
      // Pop is evaluated first, so a full FIFO being popped still accepts.
      do_write = push && (!full || pop);
      do_drop  = push && full && !pop;

      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (do_write) begin
         mem_d[wr_ptr_q] = rec;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_write, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      armed_d = 1'b1;
      prev0_d = Count0;
      prev1_d = Count1;

      // A drop on the same edge as ClrOvf wins: the flag and a count of one
      // survive the clear.
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (do_drop) begin
         ovf_d = 1'b1;
         if (ClrOvf)            drop_d = DROP_W'(1);
         else if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
      end else if (ClrOvf) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         armed_q  <= 1'b0;
         prev0_q  <= '0;
         prev1_q  <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         armed_q  <= armed_d;
         prev0_q  <= prev0_d;
         prev1_q  <= prev1_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   // Storage needs no reset: contents are only visible while OutValid=1.
   always_ff @(posedge Clk) begin
      mem_q <= mem_d;
   end

   assign OutValid = (level_q != '0);
   assign {OutChg, OutWrap, OutVal0, OutVal1} = mem_q[rd_ptr_q];
   assign Level    = level_q;
   assign Overflow = ovf_q;
   assign DropCnt  = drop_q;

endmodule

// File: tb/tb_count_change_logger.sv
module tb_count_change_logger;

   localparam int CNT_W  = 4;
   localparam int DEPTH  = 4;
   localparam int DROP_W = 8;
   localparam int REC_W  = 4 + 2 * CNT_W;

   logic              Clk = 1'b0;
   logic              Reset;
   logic [CNT_W-1:0]  Count0, Count1;
   logic              ClrOvf, OutReady;
   logic              OutValid;
   logic [1:0]        OutChg, OutWrap;
   logic [CNT_W-1:0]  OutVal0, OutVal1;
   logic [$clog2(DEPTH):0] Level;
   logic              Overflow;
   logic [DROP_W-1:0] DropCnt;

   count_change_logger #(.CNT_W(CNT_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .Clk(Clk), .Reset(Reset), .Count0(Count0), .Count1(Count1),
      .ClrOvf(ClrOvf), .OutReady(OutReady), .OutValid(OutValid),
      .OutChg(OutChg), .OutWrap(OutWrap), .OutVal0(OutVal0), .OutVal1(OutVal1),
      .Level(Level), .Overflow(Overflow), .DropCnt(DropCnt)
   );

   always #5 Clk = ~Clk;

   int n_vec = 0;
   int n_err = 0;
   logic [REC_W-1:0] sb[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Expected record: {chg, wrap, val0, val1}
   task automatic exp_rec(input logic [1:0] chg, input logic [1:0] wrap,
                          input logic [CNT_W-1:0] v0, input logic [CNT_W-1:0] v1);
      sb.push_back({chg, wrap, v0, v1});
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   // Monitor: compares each record as the handshake completes, and checks
   // that a stalled head record does not move.
   logic             hold_vld = 1'b0;
   logic [REC_W-1:0] hold_rec;
   always @(negedge Clk) begin
      logic [REC_W-1:0] cur, e;
      cur = {OutChg, OutWrap, OutVal0, OutVal1};
      if (!Reset && hold_vld && OutValid) chk("stall_stable", int'(cur), int'(hold_rec));
      if (!Reset && OutValid && OutReady) begin
         if (sb.size() == 0) chk("unexpected_record", int'(cur), -1);
         else begin
            e = sb.pop_front();
            chk("record", int'(cur), int'(e));
         end
      end
      hold_vld = !Reset && OutValid && !OutReady;
      hold_rec = cur;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1);
   end

   initial begin
      Reset = 1'b1; Count0 = '0; Count1 = '0; ClrOvf = 1'b0; OutReady = 1'b0;
      tick(2);
      chk("rst_valid", int'(OutValid), 0);
      chk("rst_level", int'(Level), 0);
      chk("rst_ovf", int'(Overflow), 0);
      chk("rst_drop", int'(DropCnt), 0);

      // Arming: steady counts produce nothing.
      Reset = 1'b0; Count0 = 4'd3; Count1 = 4'd5;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("arm_valid", int'(OutValid), 0);
         chk("arm_level", int'(Level), 0);
      end

      // Both drop to 0: below previous values, so both wrap.
      Count0 = 4'd0; Count1 = 4'd0; exp_rec(2'b11, 2'b11, 4'd0, 4'd0);
      tick();
      chk("drop0_level", int'(Level), 1);
      OutReady = 1'b1;
      tick();
      chk("drop0_drained", int'(OutValid), 0);

      // Single change 0->1 on channel 0.
      Count0 = 4'd1; exp_rec(2'b01, 2'b00, 4'd1, 4'd0);
      tick();
      chk("single_valid", int'(OutValid), 1);
      chk("single_chg", int'(OutChg), 1);
      chk("single_val0", int'(OutVal0), 1);
      tick();
      chk("single_drained", int'(OutValid), 0);

      // Simultaneous change with wrap on channel 0 only.
      Count0 = 4'd15; Count1 = 4'd2; exp_rec(2'b11, 2'b00, 4'd15, 4'd2);
      tick();
      Count0 = 4'd0; Count1 = 4'd3; exp_rec(2'b11, 2'b01, 4'd0, 4'd3);
      tick();
      chk("wrap_level", int'(Level), 1);
      chk("wrap_chg", int'(OutChg), 3);
      chk("wrap_wrap", int'(OutWrap), 1);
      chk("wrap_val1", int'(OutVal1), 3);
      tick();
      chk("wrap_drained", int'(OutValid), 0);

      // Overflow: six increments into a depth-4 FIFO, two dropped.
      OutReady = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         Count0 = CNT_W'(i);
         if (i <= 4) exp_rec(2'b01, 2'b00, CNT_W'(i), 4'd3);
         tick();
      end
      chk("ovf_level", int'(Level), 4);
      chk("ovf_flag", int'(Overflow), 1);
      chk("ovf_drop", int'(DropCnt), 2);
      chk("ovf_head", int'(OutVal0), 1);
      OutReady = 1'b1;
      tick(4);
      chk("ovf_drained", int'(OutValid), 0);
      chk("ovf_sticky", int'(Overflow), 1);
      chk("ovf_drop_kept", int'(DropCnt), 2);
      ClrOvf = 1'b1;
      tick();
      ClrOvf = 1'b0;
      chk("clr_ovf", int'(Overflow), 0);
      chk("clr_drop", int'(DropCnt), 0);

      // Full FIFO with same-edge push and pop: the push is accepted.
      OutReady = 1'b0;
      for (int i = 7; i <= 10; i++) begin
         Count0 = CNT_W'(i);
         exp_rec(2'b01, 2'b00, CNT_W'(i), 4'd3);
         tick();
      end
      chk("full_level", int'(Level), 4);
      OutReady = 1'b1; Count1 = 4'd4; exp_rec(2'b10, 2'b00, 4'd10, 4'd4);
      tick();
      chk("pushpop_level", int'(Level), 4);
      chk("pushpop_drop", int'(DropCnt), 0);
      chk("pushpop_ovf", int'(Overflow), 0);
      tick(4);
      chk("pushpop_drained", int'(OutValid), 0);

      // Drop on the same edge as ClrOvf: the drop wins.
      OutReady = 1'b0;
      for (int i = 11; i <= 14; i++) begin
         Count0 = CNT_W'(i);
         exp_rec(2'b01, 2'b00, CNT_W'(i), 4'd4);
         tick();
      end
      Count0 = 4'd15; ClrOvf = 1'b1;
      tick();
      ClrOvf = 1'b0;
      chk("clrdrop_ovf", int'(Overflow), 1);
      chk("clrdrop_cnt", int'(DropCnt), 1);
      chk("clrdrop_level", int'(Level), 4);
      OutReady = 1'b1;
      tick();
      OutReady = 1'b0;
      chk("pre_rst_level", int'(Level), 3);

      // Reset mid-operation discards stored records.
      Reset = 1'b1;
      sb.delete();
      tick();
      chk("mid_rst_valid", int'(OutValid), 0);
      chk("mid_rst_level", int'(Level), 0);
      chk("mid_rst_ovf", int'(Overflow), 0);
      chk("mid_rst_drop", int'(DropCnt), 0);
      // Count0 differs from the cleared baseline, but the first edge only arms.
      Reset = 1'b0; Count0 = 4'd2;
      tick();
      chk("rearm_level", int'(Level), 0);
      Count0 = 4'd5; exp_rec(2'b01, 2'b00, 4'd5, 4'd4);
      tick();
      chk("rearm_logged", int'(Level), 1);
      OutReady = 1'b1;
      tick();
      chk("final_drained", int'(OutValid), 0);
      chk("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/count_change_logger.md
Name: count_change_logger

Overview:
- Sits directly downstream of the two-channel event counter block and watches its two count outputs.
- Every cycle in which either count changes, it logs one record into a small first-word-fall-through FIFO. Each record holds the change flags, wrap flags and both new values.
- The records are read out with a valid/ready handshake by the debug/display side.
- A sticky overflow flag and a saturating drop counter record lost events.

Parameters:
- CNT_W, 4: width of each monitored count. Count0/Count1 connect to the low CNT_W bits of the counter outputs.
- DEPTH, 4: FIFO depth in records. Must be a power of two and at least 2.
- DROP_W, 8: width of the saturating drop counter.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Count0  input  CNT_W  channel-0 count value.
- Count1  input  CNT_W  channel-1 count value.
- ClrOvf  input  1  clears Overflow and DropCnt; sampled on the rising edge.
- OutReady  input  1  consumer accepts the head record this cycle.
- OutValid  output  1  FIFO non-empty; head record fields are valid.
- OutChg  output  2  head record change flags; bit i = channel i changed.
- OutWrap  output  2  head record wrap flags; bit i = channel i new value < previous value.
- OutVal0  output  CNT_W  head record channel-0 value.
- OutVal1  output  CNT_W  head record channel-1 value.
- Level  output  clog2(DEPTH)+1  number of stored records.
- Overflow  output  1  sticky: at least one record was dropped.
- DropCnt  output  DROP_W  number of dropped records, saturating at all-ones.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything, including mid-operation):
  - FIFO emptied, so OutValid=0 and Level=0.
  - Overflow=0, DropCnt=0, Armed=0.
  - prev0/prev1 = 0.
  - Head-field outputs are don't-care while OutValid=0; the bench must not check them.
- Arming: on the first edge after Reset deasserts, prev0/prev1 capture Count0/Count1 and Armed becomes 1. No record is logged on that edge.
- Detection, at every edge while Armed:
  - chg0 = (Count0 != prev0); chg1 = (Count1 != prev1).
  - wrapi = chgi && (Counti < previ), unsigned compare.
  - prev0/prev1 then load the current Count0/Count1.
- Push: when chg0|chg1, push the record {chg1,chg0; wrap1,wrap0; Count0; Count1}.
  - Both channels changing on the same edge produces one record with OutChg=2'b11.
- Latency: a count changing after edge k is compared at edge k+1. If the FIFO was empty, the record is on the outputs with OutValid=1 immediately after edge k+1.
- Pop: when OutValid && OutReady at an edge, the head advances. The next record, or OutValid=0 if none remain, appears after that edge.
  - OutReady while OutValid=0 has no effect.
  - Head fields must stay stable while OutValid=1 and OutReady=0.
- Simultaneous push and pop:
  - Allowed at any level, including full. Pop is evaluated first, so a push into a full FIFO with a same-cycle pop succeeds and Level stays DEPTH.
  - On an empty FIFO, push and pop cannot coincide because OutValid=0.
- Full and drop: a push with Level==DEPTH and no pop discards the new record. Stored records are unchanged.
  - Overflow is set to 1.
  - DropCnt increments by 1, saturating at 2^DROP_W-1.
- ClrOvf: sets Overflow=0 and DropCnt=0 on that edge.
  - If a drop occurs on the same edge, the drop wins: Overflow=1 and DropCnt=1.
  - ClrOvf does not affect the FIFO.
- Pointers: read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Level is a separate up/down counter, 0..DEPTH.
- Count width: a counter wrap from 2^CNT_W-1 to 0, or an upstream counter reset to 0, shows up as chg=1 and wrap=1.

Test Plan:
- Arming: Reset 2 cycles, then hold Count0=3, Count1=5 for 5 cycles -> OutValid stays 0, Level=0 throughout.
- Single change: after arming, Count0 goes 0->1 after edge k -> after edge k+1: OutValid=1, OutChg=01, OutWrap=00, OutVal0=1, OutVal1=0; with OutReady=1 one edge later -> OutValid=0.
- Simultaneous change and wrap: Count0 15->0 and Count1 2->3 in the same cycle -> one record: OutChg=11, OutWrap=01, OutVal0=0, OutVal1=3.
- Overflow, DEPTH=4: OutReady=0 with 6 consecutive Count0 increments 1..6 -> Level=4, records hold 1,2,3,4, Overflow=1, DropCnt=2. Drain with OutReady=1 -> values 1,2,3,4 in order. Then pulse ClrOvf -> Overflow=0, DropCnt=0.
- Full with push and pop: fill to 4, then in one cycle assert OutReady=1 and change Count1 -> Level stays 4, DropCnt unchanged, new record is last out.
- Reset mid-operation: Level=3 and Overflow=1, assert Reset one cycle -> OutValid=0, Level=0, Overflow=0, DropCnt=0. The next change is logged only after one arming edge.
